// File: rtl/corescore_polarfire_reset_ctrl.sv
// PLL-lock driven staged reset controller for the PolarFire corescore build.
// Qualifies a synchronised PLL lock, releases peripherals then cores, and on a
// filtered lock loss re-asserts both resets, counts the event and re-arms.
module corescore_polarfire_reset_ctrl #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned LOCK_CYCLES = 1024,
    parameter int unsigned STAGE_GAP   = 16,
    parameter int unsigned LOSS_FILTER = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_pll_lock,
    output logic             o_rst_periph,
    output logic             o_rst_core,
    output logic             o_ready,
    output logic [CNT_W-1:0] o_loss_cnt,
    output logic [2:0]       o_state
);

    localparam int unsigned CycMax = (LOCK_CYCLES > STAGE_GAP) ? LOCK_CYCLES : STAGE_GAP;
    localparam int unsigned CycW   = $clog2(CycMax + 1);
    localparam int unsigned LowW   = $clog2(LOSS_FILTER + 1);

    localparam logic [CycW-1:0] LockLast = CycW'(LOCK_CYCLES - 1);
    localparam logic [CycW-1:0] GapLast  = CycW'(STAGE_GAP - 1);
    localparam logic [LowW-1:0] LowLast  = LowW'(LOSS_FILTER - 1);

    typedef enum logic [2:0] {
        StWaitLock = 3'd0,
        StStable   = 3'd1,
        StRelease  = 3'd2,
        StRun      = 3'd3,
        StLost     = 3'd4
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CycW-1:0]        cyc_q, cyc_d;
    logic [LowW-1:0]        low_q, low_d;
    logic                   periph_q, periph_d;
    logic                   core_q, core_d;
    logic                   ready_q, ready_d;
    logic [CNT_W-1:0]       loss_q, loss_d;
    logic                   lock_s;
    logic                   watching;
    logic                   loss_hit;

    assign lock_s = sync_q[SYNC_STAGES-1];

    // Lock synchroniser: raw PLL_LOCK is asynchronous to the fabric clock.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_pll_lock};
        end
    end

    // Low-run filter only matters once the peripherals have been released.
    always_comb begin
        watching = (state_q == StRelease) || (state_q == StRun);
        loss_hit = watching && !lock_s && (low_q == LowLast);
        low_d    = '0;
        if (watching && !lock_s) begin
            low_d = low_q + LowW'(1);
        end
    end

    // Next-state and registered-output logic; losses take priority over release progress.
    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        periph_d = periph_q;
        core_d   = core_q;
        ready_d  = ready_q;
        loss_d   = loss_q;

        unique case (state_q)
            StWaitLock: begin
                cyc_d    = '0;
                periph_d = 1'b1;
                core_d   = 1'b1;
                ready_d  = 1'b0;
                if (lock_s) begin
                    state_d = StStable;
                end
            end
            StStable: begin
                if (!lock_s) begin
                    state_d = StWaitLock;
                    cyc_d   = '0;
                end else if (cyc_q == LockLast) begin
                    state_d  = StRelease;
                    cyc_d    = '0;
                    periph_d = 1'b0;
                end else begin
                    cyc_d = cyc_q + CycW'(1);
                end
            end
            StRelease: begin
                if (!loss_hit) begin
                    if (cyc_q == GapLast) begin
                        state_d = StRun;
                        cyc_d   = '0;
                        core_d  = 1'b0;
                        ready_d = 1'b1;
                    end else begin
                        cyc_d = cyc_q + CycW'(1);
                    end
                end
            end
            StRun: begin
                cyc_d = '0;
            end
            StLost: begin
                state_d = StWaitLock;
                cyc_d   = '0;
            end
            default: begin
                state_d  = StWaitLock;
                cyc_d    = '0;
                periph_d = 1'b1;
                core_d   = 1'b1;
                ready_d  = 1'b0;
            end
        endcase

        // Both resets re-assert together on the edge that enters LOST.
        if (loss_hit) begin
            state_d  = StLost;
            cyc_d    = '0;
            periph_d = 1'b1;
            core_d   = 1'b1;
            ready_d  = 1'b0;
            if (loss_q != '1) begin
                loss_d = loss_q + CNT_W'(1);
            end
        end
    end

    // State, counters and reset outputs; i_rst overrides everything.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= StWaitLock;
            cyc_q    <= '0;
            low_q    <= '0;
            periph_q <= 1'b1;
            core_q   <= 1'b1;
            ready_q  <= 1'b0;
            loss_q   <= '0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            low_q    <= low_d;
            periph_q <= periph_d;
            core_q   <= core_d;
            ready_q  <= ready_d;
            loss_q   <= loss_d;
        end
    end

    assign o_rst_periph = periph_q;
    assign o_rst_core   = core_q;
    assign o_ready      = ready_q;
    assign o_loss_cnt   = loss_q;
    assign o_state      = state_q;

endmodule

// File: tb/tb_corescore_polarfire_reset_ctrl.sv
// Self-checking bench for the PLL-lock reset controller: directed scenarios plus
// randomized lock bouncing and reset pulses, against a timestamp-based model.
module tb_corescore_polarfire_reset_ctrl;

    localparam int unsigned S  = 2;
    localparam int unsigned L  = 8;
    localparam int unsigned G  = 4;
    localparam int unsigned F  = 3;
    localparam int unsigned CW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pll_lock = 1'b0;
    logic          rst_periph;
    logic          rst_core;
    logic          ready;
    logic [CW-1:0] loss_cnt;
    logic [2:0]    state;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    // Model: timestamps of qualification start and periph release, run of lows.
    bit q_hist[$];
    int edge_n  = 0;
    int m_qual  = -1;
    int m_rel   = -1;
    bit m_core  = 1'b0;
    int m_lows  = 0;
    bit m_lost  = 1'b0;
    int m_cnt   = 0;

    corescore_polarfire_reset_ctrl #(
        .SYNC_STAGES(S),
        .LOCK_CYCLES(L),
        .STAGE_GAP  (G),
        .LOSS_FILTER(F),
        .CNT_W      (CW)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_pll_lock  (pll_lock),
        .o_rst_periph(rst_periph),
        .o_rst_core  (rst_core),
        .o_ready     (ready),
        .o_loss_cnt  (loss_cnt),
        .o_state     (state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    // Lock seen by the controller at an edge is the raw lock from S edges earlier.
    task automatic model_edge(input bit r, input bit lk);
        bit s;
        if (r) begin
            edge_n = 0;
            q_hist = {};
            for (int i = 0; i < int'(S); i++) q_hist.push_back(1'b0);
            m_qual = -1; m_rel = -1; m_core = 0; m_lows = 0; m_lost = 0; m_cnt = 0;
            return;
        end
        edge_n++;
        s = q_hist.pop_front();
        q_hist.push_back(lk);
        if (m_lost) begin
            m_lost = 0;
        end else if (m_rel < 0) begin
            if (m_qual < 0) begin
                if (s) m_qual = edge_n;
            end else if (!s) begin
                m_qual = -1;
            end else if (edge_n - m_qual == int'(L)) begin
                m_rel  = edge_n;
                m_lows = 0;
            end
        end else begin
            m_lows = s ? 0 : m_lows + 1;
            if (m_lows == int'(F)) begin
                m_lost = 1; m_rel = -1; m_qual = -1; m_core = 0; m_lows = 0;
                if (m_cnt < (1 << CW) - 1) m_cnt++;
            end else if (!m_core && (edge_n - m_rel == int'(G))) begin
                m_core = 1;
            end
        end
    endtask

    task automatic compare_all();
        int exp_state;
        exp_state = m_lost ? 4 : m_core ? 3 : (m_rel >= 0) ? 2 : (m_qual >= 0) ? 1 : 0;
        check_eq("rst_periph", 32'(rst_periph), 32'(m_rel < 0));
        check_eq("rst_core", 32'(rst_core), 32'(!m_core));
        check_eq("ready", 32'(ready), 32'(m_core));
        check_eq("state", 32'(state), 32'(exp_state));
        check_eq("loss_cnt", 32'(loss_cnt), 32'(m_cnt));
        check_eq("order", 32'(rst_periph && !rst_core), 32'd0);
    endtask

    task automatic step(input bit r, input bit lk);
        @(negedge clk);
        rst      = r;
        pll_lock = lk;
        @(posedge clk);
        model_edge(r, lk);
        #1;
        compare_all();
    endtask

    task automatic wait_run();
        for (int i = 0; i < 100 && !m_core; i++) step(1'b0, 1'b1);
        check_eq("reach_run", 32'(ready), 32'd1);
    endtask

    task automatic force_loss();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    endtask

    int exp_sat [5] = '{1, 2, 3, 3, 3};

    initial begin
        // Lock rises at edge 10 and holds.
        step(1'b1, 1'b0);
        check_eq("reset_state", 32'(state), 32'd0);
        check_eq("reset_periph", 32'(rst_periph), 32'd1);
        for (int e = 1; e <= 30; e++) begin
            step(1'b0, e >= 10);
            if (e == 19) check_eq("periph_before", 32'(rst_periph), 32'd1);
            if (e == 20) check_eq("periph_fall", 32'(rst_periph), 32'd0);
            if (e == 23) check_eq("core_before", 32'(rst_core), 32'd1);
            if (e == 24) begin
                check_eq("core_fall", 32'(rst_core), 32'd0);
                check_eq("ready_rise", 32'(ready), 32'd1);
                check_eq("cnt_zero", 32'(loss_cnt), 32'd0);
            end
        end

        // Two-cycle glitch in RUN is filtered.
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1);
            check_eq("glitch_ready", 32'(ready), 32'd1);
        end

        // Three-cycle loss in RUN: LOST on the edge sampling the third low.
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        check_eq("lost_state", 32'(state), 32'd4);
        check_eq("lost_periph", 32'(rst_periph), 32'd1);
        check_eq("lost_ready", 32'(ready), 32'd0);
        check_eq("lost_cnt", 32'(loss_cnt), 32'd1);
        step(1'b0, 1'b1);
        check_eq("after_lost", 32'(state), 32'd0);

        // Second loss, then i_rst pulse in RUN with count 2.
        wait_run();
        force_loss();
        wait_run();
        check_eq("cnt_two", 32'(loss_cnt), 32'd2);
        step(1'b1, 1'b1);
        check_eq("rst_state", 32'(state), 32'd0);
        check_eq("rst_cnt", 32'(loss_cnt), 32'd0);
        check_eq("rst_core", 32'(rst_core), 32'd1);
        check_eq("rst_ready", 32'(ready), 32'd0);
        wait_run();

        // Qualification restart after a one-cycle drop during STABLE.
        step(1'b1, 1'b0);
        for (int e = 1; e <= 20; e++) begin
            step(1'b0, e != 6);
            if (e == 16) check_eq("requal_hold", 32'(rst_periph), 32'd1);
            if (e == 17) check_eq("requal_fall", 32'(rst_periph), 32'd0);
        end
        check_eq("requal_cnt", 32'(loss_cnt), 32'd0);

        // Loss during RELEASE: core never released.
        step(1'b1, 1'b1);
        for (int e = 1; e <= 20; e++) begin
            step(1'b0, !(e >= 10 && e <= 12));
            if (e == 11) check_eq("rel_periph", 32'(rst_periph), 32'd0);
            if (e >= 11 && e <= 15) check_eq("rel_core_held", 32'(rst_core), 32'd1);
            if (e == 14) check_eq("rel_lost", 32'(state), 32'd4);
        end
        check_eq("rel_cnt", 32'(loss_cnt), 32'd1);

        // Saturation of the 2-bit loss counter.
        step(1'b1, 1'b1);
        for (int k = 0; k < 5; k++) begin
            wait_run();
            force_loss();
            check_eq("sat_cnt", 32'(loss_cnt), 32'(exp_sat[k]));
        end

        // Random lock bouncing with occasional reset pulses.
        for (int blk = 0; blk < 300; blk++) begin
            int hi;
            int lo;
            hi = int'($urandom_range(1, 30));
            lo = int'($urandom_range(1, 5));
            for (int i = 0; i < hi; i++) step($urandom_range(0, 199) == 0, 1'b1);
            for (int i = 0; i < lo; i++) step($urandom_range(0, 199) == 0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
